// File: rtl/arm_fetch_pkg.sv
// Shared fetch-side definitions: prefetch FSM encodings and fetch constants.
package arm_fetch_pkg;

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_WAIT    = 2'd1,
    F_DISCARD = 2'd2
  } fetch_state_e;

  localparam int          WORD_BYTES           = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/instr_prefetch_unit_fifo.sv
// Synchronous FIFO with flush for the prefetch unit; the head is shown
// combinationally and the last shown value is held while the FIFO is empty.
module fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [CW-1:0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] held;
  logic              do_push;
  logic              do_pop;

  assign valid   = (count != '0);
  assign do_push = push & ~flush;
  assign do_pop  = pop & valid & ~flush;
  assign dout    = valid ? mem[rd_ptr] : held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      held   <= '0;
    end else begin
      held <= dout;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

  // Storage needs no reset: it is only read while the entry is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: sequential single-outstanding fetch into a small FIFO.
// Defining PREFETCH_ABORT_EN adds mem_abort/code_abort, carried per FIFO entry.
module instr_prefetch_unit
  import arm_fetch_pkg::*;
#(
  parameter int            DEPTH        = 4,
  parameter int            AW           = 32,
  parameter logic [AW-1:0] RESET_VECTOR = AW'(DEFAULT_RESET_VECTOR)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          code_valid,
  input  logic          code_ready,
  output logic [31:0]   code,
  output logic [AW-1:0] code_pc,
  input  logic          flush,
  input  logic [AW-1:0] flush_addr
`ifdef PREFETCH_ABORT_EN
  ,
  input  logic          mem_abort,
  output logic          code_abort
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef PREFETCH_ABORT_EN
  localparam int EW = 1 + 32 + AW;
`else
  localparam int EW = 32 + AW;
`endif

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] fetch_addr_nxt;
  logic [AW-1:0] target;
  logic [AW-1:0] target_nxt;
  logic [AW-1:0] flush_tgt;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [EW-1:0] din;
  logic [EW-1:0] dout;
  logic          unused_addr_bits;
  int            cnt_after_pop;

  assign flush_tgt        = {flush_addr[AW-1:2], 2'b00};
  assign unused_addr_bits = ^flush_addr[1:0];
  assign pop              = code_valid & code_ready & ~flush;
  assign cnt_after_pop    = int'(count) - int'(pop);
  assign mem_req          = (state != F_IDLE);
  assign mem_addr         = fetch_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= F_IDLE;
      fetch_addr <= RESET_VECTOR;
      target     <= RESET_VECTOR;
    end else begin
      state      <= state_nxt;
      fetch_addr <= fetch_addr_nxt;
      target     <= target_nxt;
    end
  end

  // A new request is only issued when its response is guaranteed a FIFO slot.
  always_comb begin
    state_nxt      = state;
    fetch_addr_nxt = fetch_addr;
    target_nxt     = target;
    push           = 1'b0;
    case (state)
      F_IDLE: begin
        if (flush)                      fetch_addr_nxt = flush_tgt;
        else if (cnt_after_pop < DEPTH) state_nxt      = F_WAIT;
      end
      F_WAIT: begin
        if (flush) begin
          if (mem_ack) begin
            state_nxt      = F_IDLE;
            fetch_addr_nxt = flush_tgt;
          end else begin
            state_nxt  = F_DISCARD;
            target_nxt = flush_tgt;
          end
        end else if (mem_ack) begin
          push           = 1'b1;
          fetch_addr_nxt = fetch_addr + AW'(WORD_BYTES);
          if (cnt_after_pop + 1 >= DEPTH) state_nxt = F_IDLE;
        end
      end
      F_DISCARD: begin
        if (mem_ack) begin
          state_nxt      = F_IDLE;
          fetch_addr_nxt = flush ? flush_tgt : target;
        end else if (flush) begin
          target_nxt = flush_tgt;
        end
      end
      default: state_nxt = F_IDLE;
    endcase
  end

`ifdef PREFETCH_ABORT_EN
  assign din = {mem_abort, mem_rdata, fetch_addr};
  assign {code_abort, code, code_pc} = dout;
`else
  assign din = {mem_rdata, fetch_addr};
  assign {code, code_pc} = dout;
`endif

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (EW),
    .CW     (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .valid (code_valid),
    .count (count)
  );

endmodule
